// File: rtl/vxm_unit.sv
// Vector execution unit: two-stage lane-wise ALU between the SRF read and write-back streams.
// S1 registers the dispatched operation, S2 registers the gated lane results.
module vxm_unit #(
  parameter int NUM_STREAM_ID       = 5,
  parameter int MIN_VEC_LENGTH      = 16,
  parameter int NUM_TILES_PER_SLICE = 20
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               op_valid,
  output logic                                               op_ready,
  input  logic [2:0]                                         opcode,
  input  logic [4:0]                                         vector_length,
  input  logic [NUM_STREAM_ID-1:0]                           stream_dest,
  input  logic [0:NUM_TILES_PER_SLICE-1][MIN_VEC_LENGTH-1:0] operand1,
  input  logic [0:NUM_TILES_PER_SLICE-1][MIN_VEC_LENGTH-1:0] operand2,
  output logic                                               result_valid,
  input  logic                                               result_ready,
  output logic [0:NUM_TILES_PER_SLICE-1][MIN_VEC_LENGTH-1:0] result,
  output logic [NUM_STREAM_ID-1:0]                           result_stream_id,
  output logic [NUM_TILES_PER_SLICE-1:0]                     result_lane_mask,
  output logic [NUM_TILES_PER_SLICE-1:0]                     sat_mask,
  output logic [15:0]                                        op_count
);

  localparam int W = MIN_VEC_LENGTH;
  localparam int N = NUM_TILES_PER_SLICE;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_ADDS = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_MAX  = 3'd4;
  localparam logic [2:0] OP_MIN  = 3'd5;
  localparam logic [2:0] OP_AND  = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  logic                      s1_valid;
  logic [2:0]                s1_opcode;
  logic [4:0]                s1_len;
  logic [NUM_STREAM_ID-1:0]  s1_dest;
  logic [0:N-1][W-1:0]       s1_op1;
  logic [0:N-1][W-1:0]       s1_op2;

  logic                      s1_load;
  logic                      s2_load;
  logic [4:0]                eff_len;
  logic [0:N-1][W-1:0]       nxt_result;
  logic [N-1:0]              nxt_mask;
  logic [N-1:0]              nxt_sat;

  // Returns {sat, result} for one lane.
  function automatic logic [W:0] lane_op(input logic [2:0] opc,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W:0]     sum;
    logic [W:0]     dif;
    logic [2*W-1:0] prod;
    logic [W-1:0]   r;
    logic           s;
    sum  = {a[W-1], a} + {b[W-1], b};
    dif  = {a[W-1], a} - {b[W-1], b};
    prod = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    r    = '0;
    s    = 1'b0;
    case (opc)
      OP_ADD: begin
        r = sum[W-1:0];
        s = sum[W] ^ sum[W-1];
      end
      OP_SUB: begin
        r = dif[W-1:0];
        s = dif[W] ^ dif[W-1];
      end
      OP_ADDS: begin
        s = sum[W] ^ sum[W-1];
        if (s) r = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else   r = sum[W-1:0];
      end
      OP_MUL: begin
        r = prod[W-1:0];
        s = !((&prod[2*W-1:W-1]) || !(|prod[2*W-1:W-1]));
      end
      OP_MAX:  r = ($signed(a) > $signed(b)) ? a : b;
      OP_MIN:  r = ($signed(a) < $signed(b)) ? a : b;
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
    return {s, r};
  endfunction

  assign s2_load  = s1_valid && (!result_valid || result_ready);
  assign s1_load  = !s1_valid || s2_load;
  assign op_ready = rst && s1_load;

  // Out-of-range lengths (0 or beyond the lane count) mean a full vector.
  assign eff_len = ((s1_len == 5'd0) || (int'(s1_len) > N)) ? 5'(N) : s1_len;

  always_comb begin
    nxt_result = '0;
    nxt_mask   = '0;
    nxt_sat    = '0;
    for (int i = 0; i < N; i++) begin
      if (i < int'(eff_len)) begin
        {nxt_sat[i], nxt_result[i]} = lane_op(s1_opcode, s1_op1[i], s1_op2[i]);
        nxt_mask[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid         <= 1'b0;
      s1_opcode        <= '0;
      s1_len           <= '0;
      s1_dest          <= '0;
      s1_op1           <= '0;
      s1_op2           <= '0;
      result_valid     <= 1'b0;
      result           <= '0;
      result_stream_id <= '0;
      result_lane_mask <= '0;
      sat_mask         <= '0;
      op_count         <= '0;
    end else begin
      if (s1_load) begin
        s1_valid  <= op_valid;
        s1_opcode <= opcode;
        s1_len    <= vector_length;
        s1_dest   <= stream_dest;
        s1_op1    <= operand1;
        s1_op2    <= operand2;
      end
      if (s2_load) begin
        result_valid     <= 1'b1;
        result           <= nxt_result;
        result_stream_id <= s1_dest;
        result_lane_mask <= nxt_mask;
        sat_mask         <= nxt_sat;
      end else if (result_ready) begin
        result_valid <= 1'b0;
      end
      if (result_valid && result_ready) op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_vxm_unit.sv
// Bench for vxm_unit: directed vector table, streaming/backpressure/reset sequences,
// randomized traffic against an arithmetic reference model, and op_count wrap.
module tb_vxm_unit;

  typedef logic [0:19][15:0] vec_t;

  typedef struct {
    logic [2:0]  opc;
    logic [4:0]  vlen;
    logic [4:0]  dest;
    vec_t        op1;
    vec_t        op2;
  } op_t;

  typedef struct {
    vec_t        result;
    logic [19:0] mask;
    logic [19:0] sat;
    logic [4:0]  sid;
  } res_t;

  typedef struct {
    logic [2:0]  opc;
    logic [4:0]  vlen;
    logic [15:0] a0, b0, a1, b1, ar, br;
    logic [15:0] e0, e1, er;
    logic [19:0] emask, esat;
  } tv_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  opcode = '0;
  logic [4:0]  vector_length = '0;
  logic [4:0]  stream_dest = '0;
  vec_t        operand1 = '0;
  vec_t        operand2 = '0;
  logic        result_valid;
  logic        result_ready = 1'b0;
  vec_t        result;
  logic [4:0]  result_stream_id;
  logic [19:0] result_lane_mask;
  logic [19:0] sat_mask;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  vxm_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
    .vector_length(vector_length), .stream_dest(stream_dest), .operand1(operand1),
    .operand2(operand2), .result_valid(result_valid), .result_ready(result_ready),
    .result(result), .result_stream_id(result_stream_id), .result_lane_mask(result_lane_mask),
    .sat_mask(sat_mask), .op_count(op_count)
  );

  int          total = 0;
  int          bad = 0;
  res_t        exp_q[$];
  logic        last_rv, last_ordy;
  logic [15:0] last_cnt;
  logic        ovr_en = 1'b0;
  res_t        ovr_res;
  logic        stall_prev = 1'b0;
  res_t        stall_val;
  tv_t         tv[10];
  op_t         idle_op;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on signed lane values.
  function automatic res_t ref_model(input op_t o);
    res_t r;
    int   n;
    int   a, b, v;
    logic s;
    n = (o.vlen == 0 || o.vlen > 20) ? 20 : int'(o.vlen);
    r.result = '0; r.mask = '0; r.sat = '0; r.sid = o.dest;
    for (int i = 0; i < 20; i++) begin
      a = int'($signed(o.op1[i]));
      b = int'($signed(o.op2[i]));
      s = 1'b0;
      case (o.opc)
        3'd0: begin v = a + b; s = (v > 32767 || v < -32768); end
        3'd1: begin v = a - b; s = (v > 32767 || v < -32768); end
        3'd2: begin
          v = a + b;
          if (v > 32767) begin v = 32767; s = 1'b1; end
          else if (v < -32768) begin v = -32768; s = 1'b1; end
        end
        3'd3: begin v = a * b; s = (v > 32767 || v < -32768); end
        3'd4: v = (a > b) ? a : b;
        3'd5: v = (a < b) ? a : b;
        3'd6: v = int'(o.op1[i] & o.op2[i]);
        default: v = int'(o.op1[i] ^ o.op2[i]);
      endcase
      if (i < n) begin
        r.result[i] = 16'(v);
        r.mask[i]   = 1'b1;
        r.sat[i]    = s;
      end
    end
    return r;
  endfunction

  function automatic res_t tbl_exp(input tv_t t, input logic [4:0] dest);
    res_t r;
    r.result = '0; r.mask = t.emask; r.sat = t.esat; r.sid = dest;
    for (int i = 0; i < 20; i++)
      if (t.emask[i]) r.result[i] = (i == 0) ? t.e0 : (i == 1) ? t.e1 : t.er;
    return r;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    logic [15:0] pick[5];
    o.opc  = 3'($urandom_range(0, 7));
    o.vlen = 5'($urandom_range(0, 31));
    o.dest = 5'($urandom);
    for (int i = 0; i < 20; i++) begin
      pick[0] = 16'($urandom); pick[1] = 16'h7FFF; pick[2] = 16'h8000;
      pick[3] = 16'hFFFF;      pick[4] = 16'h0001;
      o.op1[i] = pick[$urandom_range(0, 4)];
      o.op2[i] = ($urandom_range(0, 1) == 0) ? 16'($urandom) : pick[$urandom_range(0, 4)];
    end
    return o;
  endfunction

  function automatic op_t seq_op(input int k);
    op_t o;
    o.opc  = 3'(k % 8);
    o.vlen = 5'(k % 21);
    o.dest = 5'(k);
    for (int i = 0; i < 20; i++) begin
      o.op1[i] = 16'(k * 37 + i * 1000);
      o.op2[i] = 16'(k * 911 - i * 77);
    end
    return o;
  endfunction

  // One clock: drive at posedge+1, check and score at negedge.
  task automatic cycle(input logic ov, input op_t o, input logic rr);
    res_t e;
    op_valid = ov; opcode = o.opc; vector_length = o.vlen; stream_dest = o.dest;
    operand1 = o.op1; operand2 = o.op2; result_ready = rr;
    @(negedge clk);
    last_rv = result_valid; last_ordy = op_ready; last_cnt = op_count;
    chk("op_ready", 320'(op_ready), 320'((exp_q.size() < 2) || rr));
    chk("no_stale", 320'(result_valid && exp_q.size() == 0), 320'(0));
    if (stall_prev) begin
      chk("stall_valid", 320'(result_valid), 320'(1));
      chk("stall_result", 320'(result), 320'(stall_val.result));
      chk("stall_sid", 320'(result_stream_id), 320'(stall_val.sid));
      chk("stall_mask", 320'(result_lane_mask), 320'(stall_val.mask));
      chk("stall_sat", 320'(sat_mask), 320'(stall_val.sat));
    end
    if (result_valid && rr && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("result", 320'(result), 320'(e.result));
      chk("lane_mask", 320'(result_lane_mask), 320'(e.mask));
      chk("sat_mask", 320'(sat_mask), 320'(e.sat));
      chk("stream_id", 320'(result_stream_id), 320'(e.sid));
    end
    stall_prev = result_valid && !rr;
    stall_val.result = result; stall_val.sid = result_stream_id;
    stall_val.mask = result_lane_mask; stall_val.sat = sat_mask;
    if (ov && op_ready) exp_q.push_back(ovr_en ? ovr_res : ref_model(o));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; op_valid = 1'b0; result_ready = 1'b0;
    @(negedge clk);
    chk("rst_op_ready_low", 320'(op_ready), 320'(0));
    @(posedge clk);
    #1;
    chk("rst_result_valid", 320'(result_valid), 320'(0));
    chk("rst_result", 320'(result), 320'(0));
    chk("rst_sid", 320'(result_stream_id), 320'(0));
    chk("rst_mask", 320'(result_lane_mask), 320'(0));
    chk("rst_sat", 320'(sat_mask), 320'(0));
    chk("rst_op_count", 320'(op_count), 320'(0));
    rst = 1'b1; exp_q.delete(); stall_prev = 1'b0;
    #1;
    chk("rst_op_ready_high", 320'(op_ready), 320'(1));
  endtask

  task automatic drain(input int budget, input string name);
    for (int j = 0; j < budget && exp_q.size() != 0; j++) cycle(1'b0, idle_op, 1'b1);
    chk(name, 320'(exp_q.size()), 320'(0));
  endtask

  initial begin
    op_t o;
    int  acc;
    tv[0] = '{3'd0, 5'd20, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h0001, 16'h1234, 16'h1111,
              16'h8000, 16'h0000, 16'h2345, 20'hFFFFF, 20'h00001};
    tv[1] = '{3'd2, 5'd20, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h0001, 16'h1234, 16'h1111,
              16'h7FFF, 16'h0000, 16'h2345, 20'hFFFFF, 20'h00001};
    tv[2] = '{3'd7, 5'd5, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555,
              16'hFFFF, 16'hFFFF, 16'hFFFF, 20'h0001F, 20'h00000};
    tv[3] = '{3'd7, 5'd0, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555,
              16'hFFFF, 16'hFFFF, 16'hFFFF, 20'hFFFFF, 20'h00000};
    tv[4] = '{3'd3, 5'd20, 16'h0100, 16'h0100, 16'hFFFE, 16'h0003, 16'h0002, 16'h0003,
              16'h0000, 16'hFFFA, 16'h0006, 20'hFFFFF, 20'h00001};
    tv[5] = '{3'd4, 5'd20, 16'h8000, 16'h0001, 16'hFFFF, 16'hFFFE, 16'h0003, 16'h0005,
              16'h0001, 16'hFFFF, 16'h0005, 20'hFFFFF, 20'h00000};
    tv[6] = '{3'd5, 5'd20, 16'h8000, 16'h0001, 16'hFFFF, 16'hFFFE, 16'h0003, 16'h0005,
              16'h8000, 16'hFFFE, 16'h0003, 20'hFFFFF, 20'h00000};
    tv[7] = '{3'd1, 5'd3, 16'h8000, 16'h0001, 16'h0000, 16'h0001, 16'h0005, 16'h0003,
              16'h7FFF, 16'hFFFF, 16'h0002, 20'h00007, 20'h00001};
    tv[8] = '{3'd6, 5'd25, 16'hF0F0, 16'hFF00, 16'h1234, 16'h00FF, 16'hFFFF, 16'h0F0F,
              16'hF000, 16'h0034, 16'h0F0F, 20'hFFFFF, 20'h00000};
    tv[9] = '{3'd2, 5'd20, 16'h8000, 16'hFFFF, 16'h8001, 16'hFFFF, 16'h4000, 16'h4000,
              16'h8000, 16'h8000, 16'h7FFF, 20'hFFFFF, 20'hFFFFD};
    idle_op = seq_op(0);

    do_reset();

    for (int v = 0; v < 10; v++) begin
      o.opc = tv[v].opc; o.vlen = tv[v].vlen; o.dest = 5'(v * 3 + 1);
      for (int i = 0; i < 20; i++) begin
        o.op1[i] = (i == 0) ? tv[v].a0 : (i == 1) ? tv[v].a1 : tv[v].ar;
        o.op2[i] = (i == 0) ? tv[v].b0 : (i == 1) ? tv[v].b1 : tv[v].br;
      end
      ovr_en = 1'b1; ovr_res = tbl_exp(tv[v], o.dest);
      cycle(1'b1, o, 1'b1);
      ovr_en = 1'b0;
      drain(4, "tbl_drain");
    end

    // Back-to-back stream: result visible two cycles after the op is driven.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cycle(k < 10, seq_op(k), 1'b1);
      chk("stream_latency", 320'(last_rv), 320'(k >= 2));
    end
    cycle(1'b0, idle_op, 1'b1);
    chk("stream_idle_valid", 320'(last_rv), 320'(0));
    chk("stream_op_count", 320'(last_cnt), 320'(10));

    // Backpressure: exactly two accepts, then drain in order.
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, seq_op(20 + k), 1'b0);
      if (last_ordy) acc++;
    end
    chk("bp_accepts", 320'(acc), 320'(2));
    chk("bp_ready_low", 320'(last_ordy), 320'(0));
    drain(4, "bp_drain");

    // Reset with two operations in flight: nothing stale may emerge.
    cycle(1'b1, seq_op(30), 1'b0);
    cycle(1'b1, seq_op(31), 1'b0);
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b0, idle_op, 1'b1);
    chk("midrst_valid", 320'(last_rv), 320'(0));
    chk("midrst_count", 320'(last_cnt), 320'(0));

    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 3) != 0, rand_op(), $urandom_range(0, 2) != 0);
    drain(10, "rand_drain");

    do_reset();
    for (int k = 0; k < 65537; k++) cycle(1'b1, seq_op(k % 64), 1'b1);
    drain(5, "wrap_drain");
    cycle(1'b0, idle_op, 1'b1);
    chk("wrap_op_count", 320'(last_cnt), 320'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
